// File: rtl/wb_master_cmd.sv
`default_nettype none
// ============================================================================
// Module      : wb_master_cmd
// Description : Single-outstanding command/response to Wishbone initiator.
//               Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_master_cmd #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        wb_stb_q, wb_stb_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_adr_q, wb_adr_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;

`ifdef WB_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        rsp_err_q, rsp_err_d;
    logic        tmo_hit;

    // Abort on the edge that would bring the count up to the limit.
    assign tmo_hit = (tmo_cnt_q + 16'd1) == TIMEOUT_CYCLES;
`else
    // Parameter is kept so both builds share one instantiation interface.
    if (TIMEOUT_CYCLES == 16'd0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        wb_cyc_d    = wb_cyc_q;
        wb_stb_d    = wb_stb_q;
        wb_we_d     = wb_we_q;
        wb_adr_d    = wb_adr_q;
        wb_sel_d    = wb_sel_q;
        wb_dat_d    = wb_dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        rsp_err_d   = rsp_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    wb_cyc_d = 1'b1;
                    wb_stb_d = 1'b1;
                    wb_we_d  = cmd_we;
                    wb_adr_d = cmd_adr;
                    wb_sel_d = cmd_sel;
                    wb_dat_d = cmd_dat;
                    state_d  = BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_cnt_d = 16'd0;
`endif
                end
            end
            BUS: begin
                // Ack is checked first so it wins a same-edge timeout.
                if (wb_ack_i) begin
                    wb_cyc_d    = 1'b0;
                    wb_stb_d    = 1'b0;
                    rsp_dat_d   = wb_we_q ? 32'd0 : wb_dat_i;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (tmo_hit) begin
                    wb_cyc_d    = 1'b0;
                    wb_stb_d    = 1'b0;
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_adr_q    <= 32'd0;
            wb_sel_q    <= 4'd0;
            wb_dat_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            wb_cyc_q    <= wb_cyc_d;
            wb_stb_q    <= wb_stb_d;
            wb_we_q     <= wb_we_d;
            wb_adr_q    <= wb_adr_d;
            wb_sel_q    <= wb_sel_d;
            wb_dat_q    <= wb_dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= 16'd0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign busy      = (state_q != IDLE);
    assign wb_cyc_o  = wb_cyc_q;
    assign wb_stb_o  = wb_stb_q;
    assign wb_we_o   = wb_we_q;
    assign wb_adr_o  = wb_adr_q;
    assign wb_sel_o  = wb_sel_q;
    assign wb_dat_o  = wb_dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_cmd.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_master_cmd
// Description : Self-checking bench for wb_master_cmd with a wait-state slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_master_cmd;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd4;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'd255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_master_cmd #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_sel   (cmd_sel),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    // Slave: 16-word register file, programmable wait states, optional silence.
    logic [31:0] slave_mem [16];
    logic [31:0] model_mem [16];
    int unsigned wait_states = 0;
    int unsigned wcnt = 0;
    logic        never_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        slave_ack;

    assign slave_ack = wb_cyc_o && wb_stb_o && !never_ack && (wcnt == wait_states);
    assign wb_ack_i  = slave_ack | stray_ack;
    assign wb_dat_i  = slave_ack ? slave_mem[wb_adr_o[5:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !slave_ack) wcnt <= wcnt + 1;
        else                                    wcnt <= 0;
        if (slave_ack && wb_we_o) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel_o[b]) slave_mem[wb_adr_o[5:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] last_rsp_dat = 32'd0;

    // One complete command/response exchange, predicted from the model first.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input int unsigned wait_n,
                           input int unsigned hold, input logic silent);
        int          idx;
        bit          exp_to;
        int          exp_lat;
        logic [31:0] exp_dat;
        logic [31:0] mask;
        logic [68:0] snap;
        bit          stable;
        int          k;

        idx    = int'(adr[5:2]);
        exp_to = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        exp_to = silent || ((wait_n + 1) > int'(TB_TIMEOUT));
`endif
        exp_lat = exp_to ? int'(TB_TIMEOUT) : int'(wait_n) + 1;
        exp_dat = (exp_to || we) ? 32'd0 : model_mem[idx];
        if (!exp_to && we) begin
            mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            model_mem[idx] = (model_mem[idx] & ~mask) | (dat & mask);
        end

        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid   = 1'b1;
        cmd_we      = we;
        cmd_adr     = adr;
        cmd_sel     = sel;
        cmd_dat     = dat;
        wait_states = wait_n;
        never_ack   = silent;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        check("wb_ctrl_accept", 64'({wb_cyc_o, wb_stb_o, wb_we_o, cmd_ready, busy}),
              64'({3'b11_0 | {2'b00, we}, 2'b01}));
        check("wb_adr_dat_sel", 64'({wb_adr_o, wb_sel_o, wb_dat_o[27:0]}),
              64'({adr, sel, dat[27:0]}));
        snap   = {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o};
        stable = 1'b1;
        k      = 0;
        while (!rsp_valid && k < 100) begin
            if ({wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== snap || !wb_cyc_o || !wb_stb_o
                || cmd_ready !== 1'b0)
                stable = 1'b0;
            @(negedge clk);
            k++;
        end
        check("rsp_latency", 64'(k), 64'(exp_lat));
        check("wb_stable_in_bus", 64'(stable), 64'd1);
        check("cyc_stb_drop", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
        check("rsp_err", 64'(rsp_err), 64'(exp_to));
        check("rsp_dat", 64'(rsp_dat), 64'(exp_dat));
        last_rsp_dat = rsp_dat;

        for (int h = 0; h < int'(hold); h++) begin
            stray_ack = 1'($urandom_range(1, 0));
            @(negedge clk);
            check("rsp_hold", 64'({rsp_valid, rsp_err, cmd_ready, rsp_dat}),
                  64'({1'b1, exp_to, 1'b0, exp_dat}));
        end
        stray_ack = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("consume", 64'({rsp_valid, cmd_ready, busy, wb_cyc_o}), 64'b0100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            slave_mem[i] = a;
            model_mem[i] = a;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({cmd_ready, busy, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o}),
              64'd0);
        check("reset_data", 64'({wb_adr_o, wb_dat_o} | 64'({wb_sel_o, rsp_dat})), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(cmd_ready), 64'd1);

        // GPIO-style write with registered ack, then read it back
        run_txn(1'b1, 32'h0000_0014, 4'hF, 32'h0000_A5A5, 1, 0, 1'b0);
        check("gpio_reg", 64'(slave_mem[5]), 64'h0000_A5A5);
        run_txn(1'b0, 32'h0000_0014, 4'hF, 32'h0, 1, 0, 1'b0);
        check("gpio_read", 64'(last_rsp_dat), 64'h0000_A5A5);

        // Three wait states with a slow consumer
        run_txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 3, 5, 1'b0);

        // Stray ack in IDLE
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check("stray_idle", 64'({cmd_ready, busy, rsp_valid, wb_cyc_o, rsp_dat}),
              64'({4'b1000, last_rsp_dat}));

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            run_txn(1'($urandom_range(1, 0)), a, 4'($urandom_range(15, 0)), $urandom,
                    $urandom_range(3, 0), $urandom_range(3, 0), 1'b0);
        end

`ifdef WB_MASTER_TIMEOUT_EN
        run_txn(1'b0, 32'h0000_0008, 4'hF, 32'h0, 0, 1, 1'b1);
        run_txn(1'b1, 32'h0000_0008, 4'h3, 32'h1234_5678, 3, 1, 1'b0);
`endif

        // Reset one cycle into BUS with a silent slave
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0000_0030;
        never_ack = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bus_before_reset", 64'({wb_cyc_o, wb_stb_o}), 64'b11);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_drop", 64'({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready}), 64'd0);
        @(negedge clk);
        check("reset_mid_adr", 64'({wb_adr_o, rsp_dat}), 64'd0);
        reset     = 1'b1;
        never_ack = 1'b0;
        @(posedge clk);
        #1;
        check("ready_first_edge", 64'({cmd_ready, rsp_valid, busy}), 64'b100);

        run_txn(1'b0, 32'h0000_0014, 4'hF, 32'h0, 0, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
